// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_gen
//  Description : Loads a parallel pattern and shifts it out MSB-first, one bit
//                per BIT_CYCLES clocks, in one-shot or continuous mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_gen #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             repeat_en,
    input  logic [WIDTH-1:0] pattern,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int c_bit_w = $clog2(WIDTH);
    localparam int c_cyc_w = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(WIDTH - 1);
    localparam logic [c_cyc_w-1:0] c_last_cyc = c_cyc_w'(BIT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [c_bit_w-1:0] w_bit_cnt_nxt;
    logic [c_cyc_w-1:0] r_cyc_cnt;
    logic [c_cyc_w-1:0] w_cyc_cnt_nxt;
    logic               r_done;
    logic               w_done_nxt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cyc_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cyc_cnt <= w_cyc_cnt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // The shift register is zeroed whenever we leave SHIFT, so its MSB can
    // drive bit_out directly and still read 0 while idle.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cyc_cnt_nxt = r_cyc_cnt;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt   = S_SHIFT;
                    w_shift_nxt   = pattern;
                    w_bit_cnt_nxt = c_last_bit;
                    w_cyc_cnt_nxt = '0;
                end
            end
            S_SHIFT: begin
                if (stop) begin
                    w_state_nxt   = S_IDLE;
                    w_shift_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_cyc_cnt_nxt = '0;
                end else if (r_cyc_cnt == c_last_cyc) begin
                    w_cyc_cnt_nxt = '0;
                    if (r_bit_cnt == '0) begin
                        w_done_nxt = 1'b1;
                        if (repeat_en) begin
                            w_shift_nxt   = pattern;
                            w_bit_cnt_nxt = c_last_bit;
                        end else begin
                            w_state_nxt   = S_IDLE;
                            w_shift_nxt   = '0;
                        end
                    end else begin
                        w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                    end
                end else begin
                    w_cyc_cnt_nxt = r_cyc_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_shift_nxt = '0;
            end
        endcase
    end

    assign bit_out   = r_shift[WIDTH-1];
    assign bit_valid = (r_state == S_SHIFT);
    assign busy      = (r_state == S_SHIFT);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_pattern_gen
//  Description : Self-checking bench; a behavioural model feeds per-cycle
//                expectations into scoreboard queues for two DUT instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_gen;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         repeat_en = 1'b0;
    logic [W-1:0] pattern = '0;

    logic bit_out1, bit_valid1, busy1, done1;
    logic bit_out3, bit_valid3, busy3, done3;

    int n_checks = 0;
    int n_errors = 0;

    serial_pattern_gen #(.WIDTH(W), .BIT_CYCLES(1)) u_dut1 (
        .clock(clock), .rst(rst), .start(start), .stop(stop),
        .repeat_en(repeat_en), .pattern(pattern),
        .bit_out(bit_out1), .bit_valid(bit_valid1), .busy(busy1), .done(done1)
    );

    serial_pattern_gen #(.WIDTH(W), .BIT_CYCLES(3)) u_dut3 (
        .clock(clock), .rst(rst), .start(start), .stop(stop),
        .repeat_en(repeat_en), .pattern(pattern),
        .bit_out(bit_out3), .bit_valid(bit_valid3), .busy(busy3), .done(done3)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic         m_busy [2];
    int           m_pos  [2];
    logic [W-1:0] m_pat  [2];
    logic [3:0]   q1 [$];
    logic [3:0]   q3 [$];

    task automatic model_step(input int i);
        int         bc;
        logic       dn;
        logic [3:0] e;
        bc = (i == 0) ? 1 : 3;
        dn = 1'b0;
        if (m_busy[i]) begin
            if (stop) begin
                m_busy[i] = 1'b0;
            end else if (m_pos[i] == W * bc - 1) begin
                dn = 1'b1;
                if (repeat_en) begin
                    m_pat[i] = pattern;
                    m_pos[i] = 0;
                end else begin
                    m_busy[i] = 1'b0;
                end
            end else begin
                m_pos[i]++;
            end
        end else if (start && !stop) begin
            m_busy[i] = 1'b1;
            m_pat[i]  = pattern;
            m_pos[i]  = 0;
        end
        e[3] = m_busy[i] ? m_pat[i][W-1-m_pos[i]/bc] : 1'b0;
        e[2] = m_busy[i];
        e[1] = m_busy[i];
        e[0] = dn;
        if (i == 0) q1.push_back(e);
        else        q3.push_back(e);
    endtask

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0;
                m_pos[i]  = 0;
                m_pat[i]  = '0;
            end
            q1.delete();
            q3.delete();
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clock) begin
        logic [3:0] e;
        if (!rst) begin
            check("rst_outs1", {28'd0, bit_out1, bit_valid1, busy1, done1}, 32'd0);
            check("rst_outs3", {28'd0, bit_out3, bit_valid3, busy3, done3}, 32'd0);
        end else begin
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("sb_dut1", {28'd0, bit_out1, bit_valid1, busy1, done1}, {28'd0, e});
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("sb_dut3", {28'd0, bit_out3, bit_valid3, busy3, done3}, {28'd0, e});
            end
        end
    end

    // ---------------- directed capture helpers ----------------
    logic cap_bit1 [1:40];
    logic cap_busy1[1:40];
    logic cap_done1[1:40];
    logic cap_bit3 [1:40];
    logic cap_busy3[1:40];
    logic cap_done3[1:40];

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic capture(input int n, input int chg_c, input logic [W-1:0] chg_pat);
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            #1;
            cap_bit1[c]  = bit_out1;
            cap_busy1[c] = busy1;
            cap_done1[c] = done1;
            cap_bit3[c]  = bit_out3;
            cap_busy3[c] = busy3;
            cap_done3[c] = done3;
            if (c == chg_c) pattern = chg_pat;
        end
    endtask

    function automatic logic [W-1:0] stream1(input int first);
        logic [W-1:0] s;
        for (int k = 0; k < W; k++) s[W-1-k] = cap_bit1[first+k];
        return s;
    endfunction

    function automatic int count_set(input int which, input int first, input int last);
        int n;
        n = 0;
        for (int c = first; c <= last; c++) begin
            case (which)
                0: n += int'(cap_busy1[c]);
                1: n += int'(cap_done1[c]);
                2: n += int'(cap_busy3[c]);
                default: n += int'(cap_done3[c]);
            endcase
        end
        return n;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] exp_pat;
        int           miss;

        // Reset asserted with random inputs
        start     = 1'($urandom);
        stop      = 1'($urandom);
        repeat_en = 1'($urandom);
        pattern   = W'($urandom);
        #1;
        check("rst_imm1", {28'd0, bit_out1, bit_valid1, busy1, done1}, 32'd0);
        check("rst_imm3", {28'd0, bit_out3, bit_valid3, busy3, done3}, 32'd0);
        repeat (3) @(negedge clock);
        start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
        #3 rst = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_busy1", {31'd0, busy1}, 32'd0);

        // One-shot, 8'b1011_0010
        pattern = 8'b1011_0010;
        pulse_start();
        capture(27, 0, '0);
        check("os_stream1", {24'd0, stream1(1)}, 32'hB2);
        check("os_busy1",   count_set(0, 1, 27), 8);
        check("os_done1_at9", {31'd0, cap_done1[9]}, 32'd1);
        check("os_done1_cnt", count_set(1, 1, 27), 1);
        check("os_busy3",   count_set(2, 1, 27), 24);
        check("os_done3_at25", {31'd0, cap_done3[25]}, 32'd1);
        check("os_done3_cnt", count_set(3, 1, 27), 1);

        // BIT_CYCLES=3 holding, 8'hA5
        pattern = 8'hA5;
        exp_pat = 8'hA5;
        pulse_start();
        capture(26, 0, '0);
        miss = 0;
        for (int c = 1; c <= 24; c++)
            if (cap_bit3[c] !== exp_pat[W-1-(c-1)/3]) miss++;
        check("hold3_bits", miss, 0);
        check("hold3_busy", count_set(2, 1, 26), 24);
        check("hold3_done25", {31'd0, cap_done3[25]}, 32'd1);

        // Repeat mode with mid-pass pattern change
        repeat_en = 1'b1;
        pattern   = 8'h0F;
        pulse_start();
        capture(18, 4, 8'hFF);
        check("rep_pass1", {24'd0, stream1(1)}, 32'h0F);
        check("rep_pass2", {24'd0, stream1(9)}, 32'hFF);
        check("rep_busy",  count_set(0, 1, 18), 18);
        check("rep_done9",  {31'd0, cap_done1[9]}, 32'd1);
        check("rep_done17", {31'd0, cap_done1[17]}, 32'd1);
        check("rep_done_cnt", count_set(1, 1, 18), 2);
        repeat_en = 1'b0;
        capture(8, 0, '0);
        check("rep_off_busy", count_set(0, 1, 8), 6);
        check("rep_off_done", {31'd0, cap_done1[7]}, 32'd1);
        check("rep_off_idle", {31'd0, cap_busy1[8]}, 32'd0);
        @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        repeat (2) @(negedge clock);

        // start ignored mid-pass, then stop
        pattern = 8'hC3;
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            #1;
            cap_busy1[c] = busy1;
            cap_done1[c] = done1;
            cap_busy3[c] = busy3;
            cap_done3[c] = done3;
            cap_bit1[c]  = bit_out1;
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            if (c == 6) stop = 1'b1;
            if (c == 7) stop = 1'b0;
        end
        check("stop_busy1", count_set(0, 1, 10), 6);
        check("stop_busy3", count_set(2, 1, 10), 6);
        check("stop_idle7", {30'd0, cap_busy1[7], cap_bit1[7]}, 32'd0);
        check("stop_nodone1", count_set(1, 1, 10), 0);
        check("stop_nodone3", count_set(3, 1, 10), 0);

        // start and stop together in IDLE
        @(negedge clock);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        #1;
        check("startstop_idle", {30'd0, busy1, busy3}, 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clock);

        // Asynchronous reset mid-bit-4, then fresh start
        pattern = 8'h96;
        pulse_start();
        repeat (5) @(negedge clock);
        #3 rst = 1'b0;
        #1;
        check("arst_imm1", {28'd0, bit_out1, bit_valid1, busy1, done1}, 32'd0);
        check("arst_imm3", {28'd0, bit_out3, bit_valid3, busy3, done3}, 32'd0);
        repeat (2) @(negedge clock);
        #3 rst = 1'b1;
        capture(3, 0, '0);
        check("arst_nodone", count_set(1, 1, 3) + count_set(3, 1, 3), 0);
        pulse_start();
        capture(10, 0, '0);
        check("arst_stream1", {24'd0, stream1(1)}, 32'h96);
        check("arst_done9", {31'd0, cap_done1[9]}, 32'd1);
        repeat (30) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
